// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Decides when the instruction in ID must be held. It tracks the destination of
// the single multicycle execution unit (DIV/REM, FDIV, FSQRT) in integer and FP
// pending-bit vectors. It raises the ID stall for load-use, multicycle RAW/WAW
// and multicycle structural hazards. It sequences the multicycle unit with a
// latency counter and announces that unit's writeback.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ID_*                     instruction currently in ID (sources, uses, dests, kind)
//   EX_*                     instruction currently in EX (load flag, dests)
//   flush                    squash the ID instruction (blocks issue only)
//   stall, stall_cause       combinational hold request and its priority-encoded cause
//                            (00 none, 01 load-use, 10 multicycle RAW/WAW, 11 structural)
//   mc_busy, mc_done         multicycle unit busy / one-cycle writeback pulse
//   mc_rd_addr, mc_fp        destination of the in-flight or completing op
module hazard_scoreboard #(
    parameter int unsigned MC_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_valid,
    input  logic [4:0] ID_rs1_addr,
    input  logic [4:0] ID_rs2_addr,
    input  logic [4:0] ID_frs1_addr,
    input  logic [4:0] ID_frs2_addr,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic       ID_use_frs1,
    input  logic       ID_use_frs2,
    input  logic       ID_regwrite,
    input  logic       ID_fp_regwrite,
    input  logic [4:0] ID_rd_addr,
    input  logic [4:0] ID_frd_addr,
    input  logic       ID_multicycle,
    input  logic       EX_mem_read,
    input  logic       EX_regwrite,
    input  logic       EX_fp_regwrite,
    input  logic [4:0] EX_rd_addr,
    input  logic [4:0] EX_frd_addr,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] stall_cause,
    output logic       mc_busy,
    output logic       mc_done,
    output logic [4:0] mc_rd_addr,
    output logic       mc_fp
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_int_q, pend_int_d;
    logic [31:0] pend_fp_q, pend_fp_d;
    // Latched destination of the multicycle op; both files kept so clearing is exact.
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic [4:0]  lat_frd_q, lat_frd_d;
    logic        lat_int_q, lat_int_d;
    logic        lat_fp_q, lat_fp_d;

    logic        chk;
    logic        issue;
    logic        issue_mc;
    logic        in_done;
    logic [31:0] cmp_int, cmp_fp;
    logic [31:0] eff_int, eff_fp;
    logic [31:0] set_int, set_fp;
    logic        lu_haz, mc_haz, st_haz;
    logic        lu_int, lu_fp;
    logic        raw_int, raw_fp, waw_int, waw_fp;

    localparam logic [3:0] CntLoad = 4'(MC_LAT - 1);

    assign chk      = ID_valid & ~flush;
    assign issue    = ID_valid & ~stall & ~flush;
    assign issue_mc = issue & ID_multicycle;
    assign in_done  = (state_q == StDone);

    // The completing register is masked out: WB forwarding supplies it this cycle.
    assign cmp_int = (in_done && lat_int_q) ? (32'd1 << lat_rd_q)  : 32'd0;
    assign cmp_fp  = (in_done && lat_fp_q)  ? (32'd1 << lat_frd_q) : 32'd0;
    assign eff_int = pend_int_q & ~cmp_int;
    assign eff_fp  = pend_fp_q & ~cmp_fp;

    assign set_int = (issue_mc && ID_regwrite && ID_rd_addr != 5'd0) ?
                     (32'd1 << ID_rd_addr) : 32'd0;
    assign set_fp  = (issue_mc && ID_fp_regwrite) ? (32'd1 << ID_frd_addr) : 32'd0;

    // Hazard detection
    assign lu_int = EX_mem_read & EX_regwrite & (EX_rd_addr != 5'd0) &
                    ((ID_use_rs1 & (ID_rs1_addr == EX_rd_addr)) |
                     (ID_use_rs2 & (ID_rs2_addr == EX_rd_addr)));
    assign lu_fp  = EX_mem_read & EX_fp_regwrite &
                    ((ID_use_frs1 & (ID_frs1_addr == EX_frd_addr)) |
                     (ID_use_frs2 & (ID_frs2_addr == EX_frd_addr)));

    assign raw_int = (ID_use_rs1 & (ID_rs1_addr != 5'd0) & eff_int[ID_rs1_addr]) |
                     (ID_use_rs2 & (ID_rs2_addr != 5'd0) & eff_int[ID_rs2_addr]);
    assign raw_fp  = (ID_use_frs1 & eff_fp[ID_frs1_addr]) |
                     (ID_use_frs2 & eff_fp[ID_frs2_addr]);
    assign waw_int = ID_regwrite & (ID_rd_addr != 5'd0) & eff_int[ID_rd_addr];
    assign waw_fp  = ID_fp_regwrite & eff_fp[ID_frd_addr];

    assign lu_haz = chk & (lu_int | lu_fp);
    assign mc_haz = chk & (raw_int | raw_fp | waw_int | waw_fp);
    assign st_haz = chk & ID_multicycle & (state_q == StBusy);

    always_comb begin
        stall       = lu_haz | mc_haz | st_haz;
        stall_cause = 2'b00;
        if (lu_haz) begin
            stall_cause = 2'b01;
        end else if (mc_haz) begin
            stall_cause = 2'b10;
        end else if (st_haz) begin
            stall_cause = 2'b11;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_rd_d   = lat_rd_q;
        lat_frd_d  = lat_frd_q;
        lat_int_d  = lat_int_q;
        lat_fp_d   = lat_fp_q;
        // Clear of the completing bit and set of a new issue; set wins on a collision.
        pend_int_d = (pend_int_q & ~cmp_int) | set_int;
        pend_fp_d  = (pend_fp_q & ~cmp_fp) | set_fp;

        unique case (state_q)
            StIdle: begin
                if (issue_mc) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (issue_mc) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        if (issue_mc) begin
            lat_rd_d  = ID_rd_addr;
            lat_frd_d = ID_frd_addr;
            lat_int_d = ID_regwrite & (ID_rd_addr != 5'd0);
            lat_fp_d  = ID_fp_regwrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            pend_int_q <= 32'd0;
            pend_fp_q  <= 32'd0;
            lat_rd_q   <= 5'd0;
            lat_frd_q  <= 5'd0;
            lat_int_q  <= 1'b0;
            lat_fp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_int_q <= pend_int_d;
            pend_fp_q  <= pend_fp_d;
            lat_rd_q   <= lat_rd_d;
            lat_frd_q  <= lat_frd_d;
            lat_int_q  <= lat_int_d;
            lat_fp_q   <= lat_fp_d;
        end
    end

    assign mc_busy    = (state_q == StBusy);
    assign mc_done    = in_done;
    assign mc_fp      = lat_fp_q;
    assign mc_rd_addr = lat_fp_q ? lat_frd_q : lat_rd_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes the expected output
// vector for each cycle; a negedge monitor pops and compares it. A second
// instance with MC_LAT=1 shares the inputs and is checked where flagged.
module tb_hazard_scoreboard;

    logic       clk, rst;
    logic       ID_valid;
    logic [4:0] ID_rs1_addr, ID_rs2_addr, ID_frs1_addr, ID_frs2_addr;
    logic       ID_use_rs1, ID_use_rs2, ID_use_frs1, ID_use_frs2;
    logic       ID_regwrite, ID_fp_regwrite;
    logic [4:0] ID_rd_addr, ID_frd_addr;
    logic       ID_multicycle;
    logic       EX_mem_read, EX_regwrite, EX_fp_regwrite;
    logic [4:0] EX_rd_addr, EX_frd_addr;
    logic       flush;

    logic       stall, mc_busy, mc_done, mc_fp;
    logic [1:0] stall_cause;
    logic [4:0] mc_rd_addr;
    logic       stall1, mc_busy1, mc_done1, mc_fp1;
    logic [1:0] stall_cause1;
    logic [4:0] mc_rd_addr1;

    hazard_scoreboard #(.MC_LAT(4)) u_dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_frs1_addr(ID_frs1_addr), .ID_frs2_addr(ID_frs2_addr),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_use_frs1(ID_use_frs1), .ID_use_frs2(ID_use_frs2),
        .ID_regwrite(ID_regwrite), .ID_fp_regwrite(ID_fp_regwrite),
        .ID_rd_addr(ID_rd_addr), .ID_frd_addr(ID_frd_addr),
        .ID_multicycle(ID_multicycle), .EX_mem_read(EX_mem_read),
        .EX_regwrite(EX_regwrite), .EX_fp_regwrite(EX_fp_regwrite),
        .EX_rd_addr(EX_rd_addr), .EX_frd_addr(EX_frd_addr), .flush(flush),
        .stall(stall), .stall_cause(stall_cause), .mc_busy(mc_busy),
        .mc_done(mc_done), .mc_rd_addr(mc_rd_addr), .mc_fp(mc_fp)
    );

    hazard_scoreboard #(.MC_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .ID_valid(ID_valid),
        .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
        .ID_frs1_addr(ID_frs1_addr), .ID_frs2_addr(ID_frs2_addr),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_use_frs1(ID_use_frs1), .ID_use_frs2(ID_use_frs2),
        .ID_regwrite(ID_regwrite), .ID_fp_regwrite(ID_fp_regwrite),
        .ID_rd_addr(ID_rd_addr), .ID_frd_addr(ID_frd_addr),
        .ID_multicycle(ID_multicycle), .EX_mem_read(EX_mem_read),
        .EX_regwrite(EX_regwrite), .EX_fp_regwrite(EX_fp_regwrite),
        .EX_rd_addr(EX_rd_addr), .EX_frd_addr(EX_frd_addr), .flush(flush),
        .stall(stall1), .stall_cause(stall_cause1), .mc_busy(mc_busy1),
        .mc_done(mc_done1), .mc_rd_addr(mc_rd_addr1), .mc_fp(mc_fp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       s;
        logic [1:0] c;
        logic       b;
        logic       d;
        logic [4:0] rd;
        logic       fp;
        bit         chk1;
        logic       b1;
        logic       d1;
        logic [4:0] rd1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            tests++;
            if ({stall, stall_cause, mc_busy, mc_done, mc_rd_addr, mc_fp} !==
                    {mon_e.s, mon_e.c, mon_e.b, mon_e.d, mon_e.rd, mon_e.fp} ||
                (mon_e.chk1 && ({mc_busy1, mc_done1, mc_rd_addr1} !==
                                {mon_e.b1, mon_e.d1, mon_e.rd1}))) begin
                fails++;
                $display({"FAIL %s: got stall=%b cause=%b busy=%b done=%b rd=%0d fp=%b ",
                          "lat1(busy=%b done=%b rd=%0d) want stall=%b cause=%b busy=%b ",
                          "done=%b rd=%0d fp=%b lat1(chk=%0d busy=%b done=%b rd=%0d)"},
                         mon_e.name, stall, stall_cause, mc_busy, mc_done, mc_rd_addr, mc_fp,
                         mc_busy1, mc_done1, mc_rd_addr1, mon_e.s, mon_e.c, mon_e.b, mon_e.d,
                         mon_e.rd, mon_e.fp, mon_e.chk1, mon_e.b1, mon_e.d1, mon_e.rd1);
            end
        end
    end

    task automatic clear_inputs();
        ID_valid = 0; ID_rs1_addr = 0; ID_rs2_addr = 0; ID_frs1_addr = 0; ID_frs2_addr = 0;
        ID_use_rs1 = 0; ID_use_rs2 = 0; ID_use_frs1 = 0; ID_use_frs2 = 0;
        ID_regwrite = 0; ID_fp_regwrite = 0; ID_rd_addr = 0; ID_frd_addr = 0;
        ID_multicycle = 0; EX_mem_read = 0; EX_regwrite = 0; EX_fp_regwrite = 0;
        EX_rd_addr = 0; EX_frd_addr = 0; flush = 0;
    endtask

    // Push this cycle's expectation, then advance to just after the next rising edge.
    task automatic step_full(input string n, input logic s, input logic [1:0] c,
                             input logic b, input logic d, input logic [4:0] rd,
                             input logic fp, input bit k1, input logic b1,
                             input logic d1, input logic [4:0] rd1);
        exp_t e;
        e.name = n; e.s = s; e.c = c; e.b = b; e.d = d; e.rd = rd; e.fp = fp;
        e.chk1 = k1; e.b1 = b1; e.d1 = d1; e.rd1 = rd1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string n, input logic s, input logic [1:0] c, input logic b,
                        input logic d, input logic [4:0] rd, input logic fp);
        step_full(n, s, c, b, d, rd, fp, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        step("reset", 0, 2'b00, 0, 0, 5'd0, 0);
        rst = 1'b1;

        // Load-use
        EX_mem_read = 1; EX_regwrite = 1; EX_rd_addr = 5;
        ID_valid = 1; ID_use_rs2 = 1; ID_rs2_addr = 5;
        step("lu_int", 1, 2'b01, 0, 0, 5'd0, 0);
        EX_mem_read = 0; EX_regwrite = 0; EX_rd_addr = 0;
        step("lu_bubble", 0, 2'b00, 0, 0, 5'd0, 0);
        clear_inputs();
        EX_mem_read = 1; EX_fp_regwrite = 1; EX_frd_addr = 9;
        ID_valid = 1; ID_use_frs1 = 1; ID_frs1_addr = 9;
        step("lu_fp", 1, 2'b01, 0, 0, 5'd0, 0);
        clear_inputs();
        EX_mem_read = 1; EX_regwrite = 1; EX_rd_addr = 0;
        ID_valid = 1; ID_use_rs1 = 1; ID_rs1_addr = 0;
        step("lu_x0", 0, 2'b00, 0, 0, 5'd0, 0);
        EX_rd_addr = 6; ID_use_rs1 = 0; ID_rs1_addr = 6;
        step("lu_unused_src", 0, 2'b00, 0, 0, 5'd0, 0);

        // MC RAW: FDIV f3, then FADD reading f3
        clear_inputs();
        ID_valid = 1; ID_multicycle = 1; ID_fp_regwrite = 1; ID_frd_addr = 3;
        step("fdiv_issue", 0, 2'b00, 0, 0, 5'd0, 0);
        clear_inputs();
        ID_valid = 1; ID_use_frs1 = 1; ID_frs1_addr = 3; ID_fp_regwrite = 1; ID_frd_addr = 4;
        for (int i = 0; i < 4; i++) step("raw_busy", 1, 2'b10, 1, 0, 5'd3, 1);
        step("raw_done", 0, 2'b00, 0, 1, 5'd3, 1);
        clear_inputs();
        step("raw_idle", 0, 2'b00, 0, 0, 5'd3, 1);

        // Structural, back-to-back, priority and WAW
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 7;
        step("div7_issue", 0, 2'b00, 0, 0, 5'd3, 1);
        ID_rd_addr = 8;
        for (int i = 0; i < 4; i++) step("struct", 1, 2'b11, 1, 0, 5'd7, 0);
        step("b2b_issue", 0, 2'b00, 0, 1, 5'd7, 0);
        EX_mem_read = 1; EX_regwrite = 1; EX_rd_addr = 5; ID_use_rs1 = 1; ID_rs1_addr = 5;
        step("prio_all", 1, 2'b01, 1, 0, 5'd8, 0);
        clear_inputs();
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 9;
        ID_use_rs1 = 1; ID_rs1_addr = 8;
        step("prio_raw", 1, 2'b10, 1, 0, 5'd8, 0);
        clear_inputs();
        ID_valid = 1; ID_regwrite = 1; ID_rd_addr = 8;
        for (int i = 0; i < 2; i++) step("waw", 1, 2'b10, 1, 0, 5'd8, 0);
        step("waw_completing", 0, 2'b00, 0, 1, 5'd8, 0);
        clear_inputs();
        step("b2b_idle", 0, 2'b00, 0, 0, 5'd8, 0);

        // DIV x0: nothing pending, done still pulses
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 0;
        step("div0_issue", 0, 2'b00, 0, 0, 5'd8, 0);
        clear_inputs();
        ID_valid = 1; ID_use_rs1 = 1; ID_rs1_addr = 0; ID_regwrite = 1; ID_rd_addr = 0;
        for (int i = 0; i < 4; i++) step("x0_busy", 0, 2'b00, 1, 0, 5'd0, 0);
        step("x0_done", 0, 2'b00, 0, 1, 5'd0, 0);
        clear_inputs();
        step("x0_idle", 0, 2'b00, 0, 0, 5'd0, 0);

        // Flush
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 7; flush = 1;
        EX_mem_read = 1; EX_regwrite = 1; EX_rd_addr = 5; ID_use_rs1 = 1; ID_rs1_addr = 5;
        step("flush_id", 0, 2'b00, 0, 0, 5'd0, 0);
        clear_inputs();
        step("flush_noissue", 0, 2'b00, 0, 0, 5'd0, 0);
        ID_valid = 1; ID_multicycle = 1; ID_fp_regwrite = 1; ID_frd_addr = 12;
        step("fsqrt_issue", 0, 2'b00, 0, 0, 5'd0, 0);
        clear_inputs();
        ID_valid = 1; ID_use_frs2 = 1; ID_frs2_addr = 12; flush = 1;
        for (int i = 0; i < 4; i++) step("flush_busy", 0, 2'b00, 1, 0, 5'd12, 1);
        step("flush_done", 0, 2'b00, 0, 1, 5'd12, 1);
        flush = 0;
        step("fp_cleared", 0, 2'b00, 0, 0, 5'd12, 1);

        // Reset mid-operation
        clear_inputs();
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 7;
        step("rst_issue", 0, 2'b00, 0, 0, 5'd12, 1);
        clear_inputs();
        ID_valid = 1; ID_use_rs1 = 1; ID_rs1_addr = 7;
        step("rst_busy1", 1, 2'b10, 1, 0, 5'd7, 0);
        rst = 1'b0;
        step("rst_async", 0, 2'b00, 0, 0, 5'd0, 0);
        rst = 1'b1;
        step("rst_release", 0, 2'b00, 0, 0, 5'd0, 0);
        clear_inputs();
        for (int i = 0; i < 5; i++) step("rst_quiet", 0, 2'b00, 0, 0, 5'd0, 0);

        // MC_LAT=1 instance alongside MC_LAT=4
        ID_valid = 1; ID_multicycle = 1; ID_regwrite = 1; ID_rd_addr = 7;
        step_full("lat1_issue", 0, 2'b00, 0, 0, 5'd0, 0, 1'b1, 0, 0, 5'd0);
        clear_inputs();
        step_full("lat1_c1", 0, 2'b00, 1, 0, 5'd7, 0, 1'b1, 1, 0, 5'd7);
        step_full("lat1_c2", 0, 2'b00, 1, 0, 5'd7, 0, 1'b1, 0, 1, 5'd7);
        step_full("lat1_c3", 0, 2'b00, 1, 0, 5'd7, 0, 1'b1, 0, 0, 5'd7);
        step("lat4_c4", 0, 2'b00, 1, 0, 5'd7, 0);
        step("lat4_c5", 0, 2'b00, 0, 1, 5'd7, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Stall-side counterpart to the pipeline's forwarding logic: it decides when an instruction in ID must be held, not where its operands come from.
- Tracks in-flight destinations of the single multicycle execution unit (DIV/REM, FDIV, FSQRT) in integer and FP pending-bit vectors.
- Generates the ID stall for load-use, multicycle RAW/WAW and multicycle structural hazards.
- Sequences the multicycle unit with a latency counter FSM and announces its writeback.

## Interface
Parameters:
- MC_LAT, 4: multicycle unit latency in cycles; legal range 1..16 (4-bit counter).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low
- ID_valid  input  1  ID holds a valid instruction
- ID_rs1_addr, ID_rs2_addr  input  5 each  integer source addresses
- ID_frs1_addr, ID_frs2_addr  input  5 each  FP source addresses
- ID_use_rs1, ID_use_rs2, ID_use_frs1, ID_use_frs2  input  1 each  the matching source is actually read
- ID_regwrite, ID_fp_regwrite  input  1 each  ID instruction writes the int / FP file
- ID_rd_addr, ID_frd_addr  input  5 each  ID destinations
- ID_multicycle  input  1  ID instruction executes in the multicycle unit
- EX_mem_read  input  1  EX instruction is a load
- EX_regwrite, EX_fp_regwrite  input  1 each  EX write enables
- EX_rd_addr, EX_frd_addr  input  5 each  EX destinations
- flush  input  1  squash the ID instruction (branch redirect)
- stall  output  1  hold PC and IF/ID; insert a bubble into ID/EX
- stall_cause  output  2  00 none, 01 load-use, 10 multicycle RAW/WAW, 11 structural
- mc_busy  output  1  multicycle unit in BUSY state
- mc_done  output  1  one-cycle pulse: multicycle result writes back this cycle
- mc_rd_addr  output  5  destination of the in-flight or completing op
- mc_fp  output  1  that destination is in the FP file

## Operation
- Issue: issue = ID_valid & ~stall & ~flush. The ID instruction is treated as entering EX at the closing edge.
- FSM states:
  - IDLE: on issue & ID_multicycle, go to BUSY, load cnt = MC_LAT-1, latch the destination, and set its pending bit.
  - BUSY: while cnt != 0, decrement. When cnt == 0, go to DONE at the next edge.
  - DONE: mc_done = 1. At the closing edge, clear the latched pending bit. Next state is BUSY on issue & ID_multicycle (back-to-back; new op reloaded), else IDLE.
- Destination latch:
  - Integer: set pend_int[rd] only if ID_regwrite and rd != 0.
  - FP: set pend_fp[frd] if ID_fp_regwrite.
  - Neither enable set: nothing becomes pending, but the FSM still runs and still pulses mc_done.
- Completing register: in DONE, the latched register is treated as not pending for stall evaluation; the WB-to-ID forwarding path supplies it.
- Same register cleared and set in one edge (back-to-back write of the same register): set wins.
- Hazard conditions, evaluated only when ID_valid & ~flush:
  - Load-use:
    - integer: EX_mem_read & EX_regwrite & EX_rd_addr != 0, matching a used rs1/rs2;
    - FP: EX_mem_read & EX_fp_regwrite, matching a used frs1/frs2.
  - MC RAW: a used source is pending and not completing. Integer x0 never matches.
  - MC WAW: the ID destination (same enable and x0 rules as above) is pending and not completing.
  - Structural: ID_multicycle & state == BUSY.
- stall is the OR of all hazard conditions. stall_cause gives the highest-priority active cause, in the order 01 > 10 > 11.
- flush forces stall = 0 and stall_cause = 00. It blocks issue only; an in-flight op (older) completes normally.
- mc_busy = (state == BUSY).
- mc_rd_addr / mc_fp hold their latched values until the next issue.

## Timing
- Reset (asynchronous, any time including mid-BUSY): state IDLE, cnt 0, both pending vectors 0, mc_done 0, mc_busy 0, mc_rd_addr 0, mc_fp 0. The in-flight op is abandoned with no mc_done.
- stall and stall_cause are combinational from inputs and current state, with zero-cycle latency.
- With a multicycle op issued at the edge ending cycle 0:
  - BUSY in cycles 1..MC_LAT;
  - DONE (mc_done = 1) in cycle MC_LAT+1;
  - pending cleared at the edge ending cycle MC_LAT+1.
- A dependent instruction in ID stalls in cycles 1..MC_LAT and issues in cycle MC_LAT+1.
- MC_LAT = 1: exactly one BUSY cycle, then DONE.
- All registered outputs change only on the clock edge or on reset assertion.

## Test plan
- Load-use: EX_mem_read=1, EX_regwrite=1, EX_rd_addr=5; ID uses rs2=5 -> stall=1, stall_cause=01. Next cycle EX is a bubble -> stall=0.
- MC RAW (MC_LAT=4): FDIV f3 issues in cycle 0; FADD reading frs1=3 sits in ID -> stall=1, cause=10 in cycles 1–4. Cycle 5: mc_done=1, mc_rd_addr=3, mc_fp=1, stall=0.
- Structural / back-to-back: a second DIV in ID during BUSY -> cause=11. It issues in the DONE cycle, FSM re-enters BUSY, mc_busy=1 in the following cycle, with a fresh MC_LAT count.
- WAW and x0:
  - DIV x7 in flight; ADD rd=7 in ID -> stall=1, cause=10.
  - DIV x0 in flight: no pending bit set; ID reading rs1=0 -> stall=0. mc_done still pulses, with mc_rd_addr=0.
- Flush: flush=1 with a multicycle op in ID -> stall=0, no issue, mc_busy stays 0. Flush during BUSY -> in-flight op still raises mc_done on schedule.
- Reset mid-operation: rst low in BUSY cycle 2 -> mc_busy, mc_done, mc_rd_addr, mc_fp and pending all 0 immediately. After release, a dependent instruction has stall=0.
